// File: rtl/pci_arbiter.sv
// rtl/pci_arbiter.sv - Round-robin PCI bus arbiter for four masters
//
// Purpose:
//   Grants the shared PCI bus to one of four requesting masters in round-robin
//   order. It watches FRAME/IRDY to follow the transaction and inserts a
//   one-clock turnaround with all grants released between owners.
//
// Ports:
//   clk       in   1  bus clock, all state updates on posedge
//   RST       in   1  synchronous active-low reset
//   REQ       in   4  per-device request, active low (bit i = device i)
//   GNT       out  4  per-device grant, active low, at most one bit low
//   FRAME     in   1  shared PCI FRAME, active low, monitored only
//   IRDY      in   1  shared PCI IRDY, active low, monitored only
//   GNT_ID    out  2  index of the current or most recently granted device
//   BUS_IDLE  out  1  active low, low while the arbiter sits in IDLE
//
// Configuration:
//   PCI_ARB_PARK_EN  when defined, an idle bus is parked on last_grant.

module pci_arbiter (
  input  logic       clk,
  input  logic       RST,
  input  logic [3:0] REQ,
  output logic [3:0] GNT,
  input  logic       FRAME,
  input  logic       IRDY,
  output logic [1:0] GNT_ID,
  output logic       BUS_IDLE
);

  // One-hot state encoding.
  localparam logic [3:0] S_IDLE    = 4'b0001;
  localparam logic [3:0] S_GRANTED = 4'b0010;
  localparam logic [3:0] S_BUSY    = 4'b0100;
  localparam logic [3:0] S_TURN    = 4'b1000;

  logic [3:0] state;
  logic [1:0] last_grant;
  logic [3:0] wait_cnt;
  // Low for the first edge after reset release, so the earliest grant lands
  // on the second posedge with RST high.
  logic       ready;

  logic       bus_idle;
  logic       any_req;
  logic       can_grant;
  logic [1:0] winner;
  logic [1:0] cand;
  logic       found;
  logic [3:0] grant_vec;

  assign bus_idle  = FRAME & IRDY;
  assign any_req   = ~&REQ;
  assign can_grant = ready & bus_idle & any_req;
  assign grant_vec = ~(4'b0001 << winner);
  assign BUS_IDLE  = (state != S_IDLE);

  // Round-robin search starting just after the last winner. The i == 4 pass
  // wraps back to last_grant itself, so a lone repeat requester still wins.
  always_comb begin
    winner = last_grant;
    cand   = last_grant;
    found  = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_grant + i[1:0];
      if (!found && !REQ[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

`ifdef PCI_ARB_PARK_EN
  logic parked;
  assign parked = (GNT != 4'hF);
`endif

  always_ff @(posedge clk) begin
    if (!RST) begin
      state      <= S_IDLE;
      GNT        <= 4'hF;
      GNT_ID     <= 2'd0;
      last_grant <= 2'd3;
      wait_cnt   <= 4'd0;
      ready      <= 1'b0;
    end else begin
      ready <= 1'b1;
      case (state)
        S_IDLE: begin
`ifdef PCI_ARB_PARK_EN
          if (parked && !REQ[last_grant] && bus_idle) begin
            // Parked owner asks for the bus: keep its grant, no turnaround.
            state    <= S_GRANTED;
            wait_cnt <= 4'd0;
          end else if (parked && any_req) begin
            // Another device wants the bus: drop the park for one TURN clock.
            GNT   <= 4'hF;
            state <= S_TURN;
          end else if (can_grant) begin
            GNT        <= grant_vec;
            GNT_ID     <= winner;
            last_grant <= winner;
            wait_cnt   <= 4'd0;
            state      <= S_GRANTED;
          end else if (!any_req && ready && bus_idle) begin
            GNT    <= ~(4'b0001 << last_grant);
            GNT_ID <= last_grant;
          end
`else
          if (can_grant) begin
            GNT        <= grant_vec;
            GNT_ID     <= winner;
            last_grant <= winner;
            wait_cnt   <= 4'd0;
            state      <= S_GRANTED;
          end
`endif
        end

        S_GRANTED: begin
          if (wait_cnt != 4'd15) begin
            wait_cnt <= wait_cnt + 4'd1;
          end
          // FRAME wins over a late REQ release: the master has already started.
          if (!FRAME) begin
            state <= S_BUSY;
          end else if (REQ[GNT_ID] || (wait_cnt == 4'd15)) begin
            GNT   <= 4'hF;
            state <= S_TURN;
          end
        end

        S_BUSY: begin
          if (bus_idle) begin
            GNT   <= 4'hF;
            state <= S_TURN;
          end
        end

        S_TURN: begin
          // The turnaround clock also makes the IDLE grant decision, so the
          // all-high gap between two owners is exactly one clock.
          if (can_grant) begin
            GNT        <= grant_vec;
            GNT_ID     <= winner;
            last_grant <= winner;
            wait_cnt   <= 4'd0;
            state      <= S_GRANTED;
          end else begin
            state <= S_IDLE;
          end
        end

        default: begin
          GNT   <= 4'hF;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pci_arbiter.sv
// tb/tb_pci_arbiter.sv - Scoreboard testbench for pci_arbiter

module tb_pci_arbiter;

  logic       clk;
  logic       RST;
  logic [3:0] REQ;
  logic [3:0] GNT;
  logic       FRAME;
  logic       IRDY;
  logic [1:0] GNT_ID;
  logic       BUS_IDLE;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       bidle;
  } exp_t;

  exp_t sb_q[$];

  pci_arbiter dut (
    .clk      (clk),
    .RST      (RST),
    .REQ      (REQ),
    .GNT      (GNT),
    .FRAME    (FRAME),
    .IRDY     (IRDY),
    .GNT_ID   (GNT_ID),
    .BUS_IDLE (BUS_IDLE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one clock of stimulus, queue what the outputs must be after the
  // edge, then pop and compare once the edge has passed.
  task automatic step(input string tag, input logic rst_v, input logic [3:0] req_v,
                      input logic frame_v, input logic irdy_v,
                      input logic [3:0] egnt, input logic [1:0] eid, input logic ebidle);
    exp_t e;
    logic [3:0] one_low;
    RST   = rst_v;
    REQ   = req_v;
    FRAME = frame_v;
    IRDY  = irdy_v;
    e.tag = tag;
    e.gnt = egnt;
    e.id = eid;
    e.bidle = ebidle;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check({e.tag, "_gnt"}, GNT, e.gnt);
    check({e.tag, "_id"}, {2'b00, GNT_ID}, {2'b00, e.id});
    check({e.tag, "_bidle"}, {3'b000, BUS_IDLE}, {3'b000, e.bidle});
    one_low = ($countones(~GNT) <= 1) ? 4'd1 : 4'd0;
    check({e.tag, "_onegnt"}, one_low, 4'd1);
  endtask

  task automatic s(input string tag, input logic [3:0] req_v, input logic frame_v,
                   input logic irdy_v, input logic [3:0] egnt, input logic [1:0] eid,
                   input logic ebidle);
    step(tag, 1'b1, req_v, frame_v, irdy_v, egnt, eid, ebidle);
  endtask

  task automatic do_reset();
    step("rst", 1'b0, 4'hF, 1'b1, 1'b1, 4'hF, 2'd0, 1'b0);
    step("rst", 1'b0, 4'hF, 1'b1, 1'b1, 4'hF, 2'd0, 1'b0);
    step("rst_rel", 1'b1, 4'hF, 1'b1, 1'b1, 4'hF, 2'd0, 1'b0);
  endtask

  initial begin
    RST = 1'b0;
    REQ = 4'hF;
    FRAME = 1'b1;
    IRDY = 1'b1;

`ifdef PCI_ARB_PARK_EN
    do_reset();
    s("park_first", 4'hF, 1'b1, 1'b1, 4'b0111, 2'd3, 1'b0);
    s("park_direct", 4'b0111, 1'b1, 1'b1, 4'b0111, 2'd3, 1'b1);
    s("p_busy", 4'b0111, 1'b0, 1'b0, 4'b0111, 2'd3, 1'b1);
    s("p_end", 4'hF, 1'b1, 1'b1, 4'hF, 2'd3, 1'b1);
    s("p_idle", 4'hF, 1'b1, 1'b1, 4'hF, 2'd3, 1'b0);
    s("parked", 4'hF, 1'b1, 1'b1, 4'b0111, 2'd3, 1'b0);
    s("p_release", 4'b1110, 1'b1, 1'b1, 4'hF, 2'd3, 1'b1);
    s("p_grant0", 4'b1110, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b1);
    s("p_drop", 4'hF, 1'b1, 1'b1, 4'hF, 2'd0, 1'b1);
    s("p_idle2", 4'hF, 1'b1, 1'b1, 4'hF, 2'd0, 1'b0);
    s("parked0", 4'hF, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b0);
`else
    do_reset();
    s("idle_noreq", 4'hF, 1'b1, 1'b1, 4'hF, 2'd0, 1'b0);

    // Single grant to device 0, then a transaction that ignores REQ changes.
    s("g0", 4'b1110, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b1);
    s("busy0", 4'b1110, 1'b0, 1'b1, 4'b1110, 2'd0, 1'b1);
    s("busy_rel", 4'hF, 1'b0, 1'b0, 4'b1110, 2'd0, 1'b1);
    s("busy_irdy", 4'hF, 1'b1, 1'b0, 4'b1110, 2'd0, 1'b1);
    s("end0", 4'hF, 1'b1, 1'b1, 4'hF, 2'd0, 1'b1);
    s("idle0", 4'hF, 1'b1, 1'b1, 4'hF, 2'd0, 1'b0);

    // All four requesting: order 0,1,2,3,0 with one all-high clock between.
    do_reset();
    begin
      int order[5] = '{0, 1, 2, 3, 0};
      for (int n = 0; n < 5; n++) begin
        logic [1:0] kk;
        logic [3:0] eg;
        kk = order[n][1:0];
        eg = ~(4'b0001 << kk);
        s("rr_gnt", 4'b0000, 1'b1, 1'b1, eg, kk, 1'b1);
        for (int c = 0; c < 3; c++) begin
          s("rr_frame", 4'b0000, 1'b0, 1'b0, eg, kk, 1'b1);
        end
        s("rr_turn", 4'b0000, 1'b1, 1'b1, 4'hF, kk, 1'b1);
      end
    end
    s("rr_idle", 4'hF, 1'b1, 1'b1, 4'hF, 2'd0, 1'b0);

    // Start timeout on device 2; device 3 is granted after the turnaround.
    s("to_gnt", 4'b0011, 1'b1, 1'b1, 4'b1011, 2'd2, 1'b1);
    for (int c = 0; c < 15; c++) begin
      s("to_hold", 4'b0011, 1'b1, 1'b1, 4'b1011, 2'd2, 1'b1);
    end
    s("to_rel", 4'b0011, 1'b1, 1'b1, 4'hF, 2'd2, 1'b1);
    s("to_next", 4'b0011, 1'b1, 1'b1, 4'b0111, 2'd3, 1'b1);
    s("to_drop", 4'hF, 1'b1, 1'b1, 4'hF, 2'd3, 1'b1);
    s("to_idle", 4'hF, 1'b1, 1'b1, 4'hF, 2'd3, 1'b0);

    // Device 1 withdraws before FRAME; grant moves on to device 3.
    s("r1_gnt", 4'b0101, 1'b1, 1'b1, 4'b1101, 2'd1, 1'b1);
    s("r1_drop", 4'b0111, 1'b1, 1'b1, 4'hF, 2'd1, 1'b1);
    s("r1_next", 4'b0111, 1'b1, 1'b1, 4'b0111, 2'd3, 1'b1);
    s("r1_busy", 4'hF, 1'b0, 1'b1, 4'b0111, 2'd3, 1'b1);
    s("r1_end", 4'hF, 1'b1, 1'b1, 4'hF, 2'd3, 1'b1);
    s("r1_idle", 4'hF, 1'b1, 1'b1, 4'hF, 2'd3, 1'b0);

    // Reset during BUSY, then first grant only on the second edge after release.
    s("rb_gnt", 4'b1011, 1'b1, 1'b1, 4'b1011, 2'd2, 1'b1);
    s("rb_busy", 4'b1011, 1'b0, 1'b0, 4'b1011, 2'd2, 1'b1);
    step("rb_rst", 1'b0, 4'b1011, 1'b0, 1'b0, 4'hF, 2'd0, 1'b0);
    step("rb_rst2", 1'b0, 4'b1011, 1'b1, 1'b1, 4'hF, 2'd0, 1'b0);
    step("rb_rel", 1'b1, 4'b1110, 1'b1, 1'b1, 4'hF, 2'd0, 1'b0);
    s("rb_first", 4'b1110, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b1);
    s("rb_drop", 4'hF, 1'b1, 1'b1, 4'hF, 2'd0, 1'b1);
    s("rb_idle", 4'hF, 1'b1, 1'b1, 4'hF, 2'd0, 1'b0);

    // Stray master drives FRAME while idle: no grant until the bus is idle.
    s("stray", 4'b1101, 1'b0, 1'b1, 4'hF, 2'd0, 1'b0);
    s("stray2", 4'b1101, 1'b0, 1'b0, 4'hF, 2'd0, 1'b0);
    s("stray_end", 4'b1101, 1'b1, 1'b1, 4'b1101, 2'd1, 1'b1);
    s("st_drop", 4'hF, 1'b1, 1'b1, 4'hF, 2'd1, 1'b1);
    s("st_idle", 4'hF, 1'b1, 1'b1, 4'hF, 2'd1, 1'b0);

    // Sub-clock REQ glitch between edges must be ignored.
    REQ = 4'b1110;
    #3;
    REQ = 4'hF;
    s("glitch", 4'hF, 1'b1, 1'b1, 4'hF, 2'd1, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
